// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird LED column.
// Holds the game state encoding and the default geometry/timing constants so the
// controller, the row-light cell array and the display agree on the same values.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int unsigned FLAPPY_ROWS      = 8;
    localparam int unsigned FLAPPY_TICK_DIV  = 25_000_000;
    localparam int unsigned FLAPPY_SCORE_W   = 4;
    localparam int unsigned FLAPPY_OVER_HOLD = 8;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings (key, pipe
// logic, row-light cells, score display).
//   key       raw flap key, 1 = pressed (asynchronous)
//   bird_row  lightOn vector of the bird-row cells
//   pipe_col  pipe pixels in the bird's column
//   enable    one-cycle game tick to the cells
//   up        flap command, valid with enable
//   gameOver  freeze to the cells
//   clear     one-cycle cell reinitialise at game start
//   score     points in the current or last game
//   state     controller state (IDLE/PLAY/OVER)
// slave is the controller side, master is the environment side.
interface flappy_game_ctrl_if
    import flappy_pkg::*;
#(
    parameter int unsigned ROWS    = FLAPPY_ROWS,
    parameter int unsigned SCORE_W = FLAPPY_SCORE_W
);

    logic               key;
    logic [ROWS-1:0]    bird_row;
    logic [ROWS-1:0]    pipe_col;
    logic               enable;
    logic               up;
    logic               gameOver;
    logic               clear;
    logic [SCORE_W-1:0] score;
    game_state_t        state;

    modport master (
        output key, bird_row, pipe_col,
        input  enable, up, gameOver, clear, score, state
    );

    modport slave (
        input  key, bird_row, pipe_col,
        output enable, up, gameOver, clear, score, state
    );

endinterface

// File: rtl/key_flap_sync.sv
// Key synchroniser and press detector.
// Two-flop synchroniser followed by a registered rising-edge detect, so a press
// yields a single one-cycle pulse on the third clk edge after the key rises;
// holding the key down produces no further pulses.
//   clk     system clock
//   reset   asynchronous active-low reset
//   key_i   raw asynchronous key, 1 = pressed
//   flap_o  one-cycle press pulse
module key_flap_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic flap_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic flap_q,  flap_d;

    always_comb begin
        sync1_d = key_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        flap_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            flap_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            flap_q  <= flap_d;
        end
    end

    assign flap_o = flap_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer.
// Generates the periodic game tick, forwards flaps as an up command on the tick,
// detects collisions between the bird row and the pipe column, keeps score and
// sequences IDLE -> PLAY -> OVER -> IDLE. All outputs are registered.
//   clk    system clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    slave side of flappy_game_ctrl_if (key, bird_row, pipe_col in;
//          enable, up, gameOver, clear, score, state out)
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned ROWS      = FLAPPY_ROWS,
    parameter int unsigned TICK_DIV  = FLAPPY_TICK_DIV,  // at least 2
    parameter int unsigned SCORE_W   = FLAPPY_SCORE_W,
    parameter int unsigned OVER_HOLD = FLAPPY_OVER_HOLD
) (
    input  logic                     clk,
    input  logic                     reset,
    flappy_game_ctrl_if.slave        bus
);

    localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(OVER_HOLD);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               pending_q, pending_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               enable_q, enable_d;
    logic               up_q, up_d;
    logic               gameover_q, gameover_d;
    logic               clear_q, clear_d;

    logic flap;
    logic tick;
    logic hit;

    key_flap_sync u_key_sync (
        .clk    (clk),
        .reset  (reset),
        .key_i  (bus.key),
        .flap_o (flap)
    );

    // An empty bird row means the bird has left the column, which also ends the game.
    assign hit  = ((bus.bird_row & bus.pipe_col) != '0) || (bus.bird_row == '0);
    assign tick = ((state_q == PLAY) || (state_q == OVER)) && (cnt_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        score_d   = score_q;
        enable_d  = 1'b0;
        up_d      = 1'b0;
        clear_d   = 1'b0;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                hold_d    = '0;
                pending_d = 1'b0;
                // The starting flap only starts the game; it is never forwarded.
                if (flap) begin
                    state_d = PLAY;
                    clear_d = 1'b1;
                    score_d = '0;
                end
            end

            PLAY: begin
                if (flap) begin
                    pending_d = 1'b1;
                end
                if (tick) begin
                    // A flap landing on the tick is consumed by this tick.
                    pending_d = 1'b0;
                    if (hit) begin
                        state_d = OVER;
                        hold_d  = '0;
                    end else begin
                        enable_d = 1'b1;
                        up_d     = pending_q | flap;
                        if ((bus.pipe_col != '0) && (score_q != SCORE_MAX)) begin
                            score_d = score_q + 1'b1;
                        end
                    end
                end
            end

            OVER: begin
                pending_d = 1'b0;
                if (tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
                // Flaps are ignored until the hold period has elapsed.
                if (flap && (hold_q == HOLD_MAX)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                hold_d    = '0;
                pending_d = 1'b0;
            end
        endcase

        gameover_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            score_q    <= '0;
            enable_q   <= 1'b0;
            up_q       <= 1'b0;
            gameover_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            score_q    <= score_d;
            enable_q   <= enable_d;
            up_q       <= up_d;
            gameover_q <= gameover_d;
            clear_q    <= clear_d;
        end
    end

    assign bus.enable   = enable_q;
    assign bus.up       = up_q;
    assign bus.gameOver = gameover_q;
    assign bus.clear    = clear_q;
    assign bus.score    = score_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with ROWS=8, TICK_DIV=4, SCORE_W=4, OVER_HOLD=2.
module tb_flappy_game_ctrl;
    import flappy_pkg::*;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned OVER_HOLD = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    flappy_game_ctrl_if #(.ROWS(ROWS), .SCORE_W(SCORE_W)) bus ();

    flappy_game_ctrl #(
        .ROWS      (ROWS),
        .TICK_DIV  (TICK_DIV),
        .SCORE_W   (SCORE_W),
        .OVER_HOLD (OVER_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance negedge by negedge until enable is seen or the budget runs out.
    task automatic wait_enable(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.enable === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit en_seen;
        bit clr_seen;
        bit st_bad;
        reset        = 1'b1;
        bus.key      = 1'b0;
        bus.bird_row = 8'h08;
        bus.pipe_col = 8'h00;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.state !== IDLE || bus.score !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d score=%0d required 0/0", bus.state, bus.score);
        end
        checks++;
        if ({bus.enable, bus.up, bus.gameOver, bus.clear} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: en/up/go/clr=%b required 0000",
                     {bus.enable, bus.up, bus.gameOver, bus.clear});
        end
        reset    = 1'b1;
        en_seen  = 1'b0;
        clr_seen = 1'b0;
        st_bad   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.enable !== 1'b0) en_seen = 1'b1;
            if (bus.clear !== 1'b0) clr_seen = 1'b1;
            if (bus.state !== IDLE) st_bad = 1'b1;
        end
        checks++;
        if (st_bad || en_seen || clr_seen) begin
            errors++;
            $display("FAIL idle_quiet: left_idle=%0b enable_seen=%0b clear_seen=%0b required 0/0/0",
                     st_bad, en_seen, clr_seen);
        end
        checks++;
        if (bus.score !== 4'd0) begin
            errors++;
            $display("FAIL idle_score: score=%0d required 0", bus.score);
        end
    endtask

    task automatic test_start();
        int first_clr;
        int n_clr;
        int first_en;
        int n_en;
        int n_up;
        first_clr = -1;
        n_clr     = 0;
        first_en  = -1;
        n_en      = 0;
        n_up      = 0;
        bus.key   = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 10) bus.key = 1'b0;
            if (bus.clear === 1'b1) begin
                n_clr++;
                if (first_clr < 0) first_clr = i;
            end
            if (bus.enable === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = i;
                if (bus.up === 1'b1) n_up++;
            end
        end
        checks++;
        if (first_clr != 4 || n_clr != 1) begin
            errors++;
            $display("FAIL start_clear: first=%0d count=%0d required 4/1", first_clr, n_clr);
        end
        checks++;
        if (first_en != 8 || n_en != 2) begin
            errors++;
            $display("FAIL start_enable: first=%0d count=%0d required 8/2", first_en, n_en);
        end
        checks++;
        if (n_up != 0) begin
            errors++;
            $display("FAIL start_no_up: up_count=%0d required 0", n_up);
        end
        checks++;
        if (bus.state !== PLAY) begin
            errors++;
            $display("FAIL start_state: state=%0d required 1", bus.state);
        end
    endtask

    task automatic test_flap();
        bit got;
        wait_enable(8, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL flap_sync_enable: enable not seen, required within 8 cycles");
        end
        // Flap lands on the next tick edge.
        bus.key = 1'b1;
        @(negedge clk);
        bus.key = 1'b0;
        wait_enable(8, got);
        checks++;
        if (!got || bus.up !== 1'b1) begin
            errors++;
            $display("FAIL flap_coincide_up: got=%0b up=%0b required 1/1", got, bus.up);
        end
        wait_enable(8, got);
        checks++;
        if (!got || bus.up !== 1'b0) begin
            errors++;
            $display("FAIL flap_next_up: got=%0b up=%0b required 1/0", got, bus.up);
        end
        // Two separate presses that both resolve between ticks.
        @(negedge clk);
        bus.key = 1'b1;
        @(negedge clk);
        bus.key = 1'b0;
        @(negedge clk);
        bus.key = 1'b1;
        @(negedge clk);
        bus.key = 1'b0;
        checks++;
        if (bus.enable !== 1'b1 || bus.up !== 1'b0) begin
            errors++;
            $display("FAIL flap_early_tick: enable=%0b up=%0b required 1/0", bus.enable, bus.up);
        end
        wait_enable(8, got);
        checks++;
        if (!got || bus.up !== 1'b1) begin
            errors++;
            $display("FAIL flap_pending_up: got=%0b up=%0b required 1/1", got, bus.up);
        end
        wait_enable(8, got);
        checks++;
        if (!got || bus.up !== 1'b0 || bus.score !== 4'd0) begin
            errors++;
            $display("FAIL flap_single_up: got=%0b up=%0b score=%0d required 1/0/0",
                     got, bus.up, bus.score);
        end
    endtask

    task automatic test_score();
        bit got;
        int exp_score;
        bus.bird_row = 8'h08;
        bus.pipe_col = 8'hF0;
        for (int k = 1; k <= 20; k++) begin
            exp_score = (k < 15) ? k : 15;
            wait_enable(8, got);
            checks++;
            if (!got || bus.score !== 4'(exp_score) || bus.gameOver !== 1'b0) begin
                errors++;
                $display("FAIL score_tick%0d: got=%0b score=%0d gameOver=%0b required 1/%0d/0",
                         k, got, bus.score, bus.gameOver, exp_score);
            end
        end
    endtask

    task automatic test_collision();
        bit en_seen;
        bit up_seen;
        en_seen      = 1'b0;
        up_seen      = 1'b0;
        bus.bird_row = 8'h10;
        bus.pipe_col = 8'h10;
        bus.key      = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.key = 1'b0;
            if (bus.enable !== 1'b0) en_seen = 1'b1;
            if (bus.up !== 1'b0) up_seen = 1'b1;
        end
        checks++;
        if (bus.state !== OVER || bus.gameOver !== 1'b1) begin
            errors++;
            $display("FAIL collide_over: state=%0d gameOver=%0b required 2/1",
                     bus.state, bus.gameOver);
        end
        checks++;
        if (en_seen || up_seen || bus.score !== 4'd15) begin
            errors++;
            $display("FAIL collide_suppress: enable_seen=%0b up_seen=%0b score=%0d required 0/0/15",
                     en_seen, up_seen, bus.score);
        end
    endtask

    task automatic test_hold_restart();
        bit left;
        // First press resolves after one OVER tick: must be ignored.
        @(negedge clk);
        bus.key = 1'b1;
        @(negedge clk);
        bus.key = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.state !== OVER || bus.gameOver !== 1'b1) begin
            errors++;
            $display("FAIL hold_ignore: state=%0d gameOver=%0b required 2/1",
                     bus.state, bus.gameOver);
        end
        // Second press resolves after two OVER ticks: returns to IDLE.
        bus.key = 1'b1;
        left    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.key = 1'b0;
            if (bus.state === IDLE) begin
                left = 1'b1;
                break;
            end
        end
        checks++;
        if (!left || bus.gameOver !== 1'b0 || bus.score !== 4'd15) begin
            errors++;
            $display("FAIL hold_restart: reached_idle=%0b gameOver=%0b score=%0d required 1/0/15",
                     left, bus.gameOver, bus.score);
        end
    endtask

    task automatic test_bird_left();
        bit got;
        bit en_seen;
        bus.bird_row = 8'h08;
        bus.pipe_col = 8'h80;
        bus.key      = 1'b1;
        got          = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.key = 1'b0;
            if (bus.clear === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || bus.score !== 4'd0 || bus.state !== PLAY) begin
            errors++;
            $display("FAIL restart_clear: clear=%0b score=%0d state=%0d required 1/0/1",
                     got, bus.score, bus.state);
        end
        wait_enable(8, got);
        checks++;
        if (!got || bus.score !== 4'd1) begin
            errors++;
            $display("FAIL restart_score: got=%0b score=%0d required 1/1", got, bus.score);
        end
        bus.bird_row = 8'h00;
        en_seen      = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.enable !== 1'b0) en_seen = 1'b1;
        end
        checks++;
        if (bus.state !== OVER || bus.gameOver !== 1'b1 || bus.score !== 4'd1 || en_seen) begin
            errors++;
            $display("FAIL bird_left: state=%0d gameOver=%0b score=%0d enable_seen=%0b required 2/1/1/0",
                     bus.state, bus.gameOver, bus.score, en_seen);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset        = 1'b1;
        bus.bird_row = 8'h08;
        bus.pipe_col = 8'h80;
        bus.key      = 1'b1;
        @(negedge clk);
        bus.key = 1'b0;
        wait_enable(16, got);
        checks++;
        if (!got || bus.state !== PLAY || bus.score !== 4'd1) begin
            errors++;
            $display("FAIL areset_pre: got=%0b state=%0d score=%0d required 1/1/1",
                     got, bus.state, bus.score);
        end
        // Mid-cycle, well clear of the next rising edge.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== IDLE || bus.score !== 4'd0 ||
            {bus.enable, bus.up, bus.gameOver, bus.clear} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_async: state=%0d score=%0d en/up/go/clr=%b required 0/0/0000",
                     bus.state, bus.score, {bus.enable, bus.up, bus.gameOver, bus.clear});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start();
        test_flap();
        test_score();
        test_collision();
        test_hold_restart();
        test_bird_left();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Game sequencer for the Flappy Bird LED column. It generates the periodic `enable` tick that steps every bird-row light cell, and converts the raw flap key into a one-tick `up` pulse.
- It checks for collisions between the bird row and the pipe column at the bird's position, keeps score, and owns the `gameOver` freeze and the restart sequencing.
- It sits between the key/pipe logic and the array of row-light cells. Its `enable`, `up`, `gameOver` and `clear` outputs fan out to every cell.

Parameters:
- ROWS, 8, number of bird-row light cells (width of `bird_row` and `pipe_col`).
- TICK_DIV, 25_000_000, clk cycles per game tick; must be at least 2.
- SCORE_W, 4, score counter width.
- OVER_HOLD, 8, ticks that must elapse in OVER before a flap restarts the game.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- key  in  1  raw, asynchronous flap key; 1 = pressed
- bird_row  in  ROWS  current lightOn vector of the bird-row cells; one-hot during play
- pipe_col  in  ROWS  pipe pixels in the bird's column; 1 = pipe present
- enable  out  1  one-cycle game tick to the cells
- up  out  1  flap command, valid in the `enable` cycle
- gameOver  out  1  freeze to the cells
- clear  out  1  one-cycle pulse that reinitialises the cells at game start
- score  out  SCORE_W  points scored in the current or last game
- state  out  2  IDLE=0, PLAY=1, OVER=2

Behaviour:
- Reset: while `reset` = 0, all of the following hold, asynchronously:
  - state = IDLE, score = 0;
  - enable, up, gameOver and clear are 0;
  - the tick counter, hold counter, synchroniser and flap_pending are cleared.
- Key path:
  - Two-flop synchroniser, then rising-edge detect.
  - `flap` is asserted for 1 cycle, on the 3rd clk edge after `key` rises.
  - Holding `key` produces only one flap.
- Tick counter:
  - Counts 0..TICK_DIV-1 in PLAY and OVER, and is held at 0 in IDLE.
  - `tick` is internal and true when count = TICK_DIV-1; the count then wraps to 0.
  - Leaving IDLE, the first tick occurs TICK_DIV cycles after the transition.
- flap_pending:
  - Set by `flap` in PLAY and cleared in the `tick` cycle.
  - If `flap` and `tick` occur in the same cycle, that tick uses pending=1 and the new flap is absorbed by it.
- Outputs are registered (Moore):
  - `enable` = 1 in the cycle after a PLAY tick.
  - `up` = 1 in that same cycle if flap_pending was 1 at the tick (or a flap coincided with it); otherwise `up` = 0.
- IDLE:
  - gameOver = 0, enable = 0.
  - A flap moves to PLAY. `clear` is pulsed for 1 cycle (the cycle after the flap), score is set to 0, and the starting flap is not forwarded.
- PLAY, evaluated on each tick:
  - hit = (bird_row & pipe_col) != 0, OR bird_row == 0 (the bird left the column).
  - If hit: go to OVER, suppress enable/up for this tick, discard the pending flap, and leave score unchanged.
  - Else, if pipe_col != 0: score is incremented, saturating at 2^SCORE_W-1.
  - Else: no change.
  - Collision takes priority over flap and over scoring.
- OVER:
  - gameOver = 1 and enable = 0.
  - The hold counter increments on each tick, saturating at OVER_HOLD.
  - A flap before the hold counter reaches OVER_HOLD is ignored.
  - A flap after the hold counter reaches OVER_HOLD goes to IDLE. score is retained until the next start.
- Reset mid-game forces IDLE immediately. No `clear` pulse is generated by reset itself, because the cells have their own reset.
- Unused encoding state=3 recovers to IDLE on the next clock.

Decomposition:
- Shared package `flappy_pkg`: the game_state_t enum (IDLE, PLAY, OVER, 2 bits) and the default constants ROWS, TICK_DIV and SCORE_W, so the cell array and the display use the same values.
- One sub-module: `key_flap_sync` (2FF synchroniser plus rising-edge pulse). It is reusable for other keys.
- The tick counter and FSM stay in the top module.

Test Plan (ROWS=8, TICK_DIV=4, SCORE_W=4, OVER_HOLD=2):
- Reset then idle: reset=0 for 2 cycles, release, key=0 for 20 cycles -> state=0, enable never 1, score=0, clear=0.
- Start: key 0->1 held 10 cycles -> exactly one clear pulse 4 cycles after the rise, state=1, first enable 4 cycles after clear with up=0, and no second flap from the held key.
- Flap forwarding: in PLAY, bird_row=8'h08, pipe_col=0, key pulsed once mid-tick -> the next enable cycle has up=1; the following enable has up=0. Two flaps within one tick give a single up.
- Scoring and saturation: bird_row=8'h08, pipe_col=8'hF0 for 20 ticks -> score goes 1,2,...,15 and stays at 15 with no gameOver.
- Collision priority: bird_row=8'h10, pipe_col=8'h10, key pulsed in the same tick -> state=2, gameOver=1, enable/up suppressed, score unchanged; bird_row=0 on a later game also gives OVER.
- Hold and restart, then async reset: in OVER, flap after 1 tick -> ignored; flap after 2 ticks -> state=0, gameOver=0, score retained. Start again and assert reset=0 mid-cycle -> outputs clear without waiting for a clk edge.
